// File: rtl/argmax_classifier.sv
// Terminal argmax stage: captures a packed signed score vector and scans it
// SCAN_FACTOR lanes per cycle, reporting the lowest-index maximum and its value.
module argmax_classifier #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SCAN_FACTOR = 4,
  parameter int unsigned IDX_WIDTH   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_valid,
  output logic                              i_ready,
  input  logic [NUM_CLASSES*DATA_WIDTH-1:0] i_scores,
  output logic                              o_valid,
  input  logic                              o_ready,
  output logic [IDX_WIDTH-1:0]              o_class,
  output logic [DATA_WIDTH-1:0]             o_max_score
);

  localparam int unsigned NUM_CHUNKS = (NUM_CLASSES + SCAN_FACTOR - 1) / SCAN_FACTOR;
  localparam int unsigned CHUNK_W    = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned NUM_LANES  = NUM_CHUNKS * SCAN_FACTOR;
  localparam int unsigned LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(NUM_CHUNKS - 1);
  localparam logic signed [DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                        state;
  logic signed [DATA_WIDTH-1:0]  elems_q [NUM_CLASSES];
  logic [CHUNK_W-1:0]            chunk_q;
  logic signed [DATA_WIDTH-1:0]  best_score_q;
  logic [IDX_WIDTH-1:0]          best_idx_q;

  logic [LANE_W-1:0]             lane_c;
  logic signed [DATA_WIDTH-1:0]  lane_val_c;
  logic                          found_c;
  logic signed [DATA_WIDTH-1:0]  chunk_max_c;
  logic [IDX_WIDTH-1:0]          chunk_idx_c;
  logic                          take_c;
  logic signed [DATA_WIDTH-1:0]  merged_score_c;
  logic [IDX_WIDTH-1:0]          merged_idx_c;

  // Chunk winner (strict > keeps lowest index; padding lanes never compete),
  // then merge with the running best. The first chunk loads unconditionally so
  // an all-minimum vector still reports element 0.
  always_comb begin
    lane_c      = '0;
    lane_val_c  = '0;
    found_c     = 1'b0;
    chunk_max_c = MIN_SCORE;
    chunk_idx_c = '0;
    for (int l = 0; l < int'(SCAN_FACTOR); l++) begin
      lane_c = LANE_W'(int'(chunk_q) * int'(SCAN_FACTOR) + l);
      if (32'(lane_c) < NUM_CLASSES) begin
        lane_val_c = elems_q[IDX_WIDTH'(lane_c)];
        if (!found_c || (lane_val_c > chunk_max_c)) begin
          chunk_max_c = lane_val_c;
          chunk_idx_c = IDX_WIDTH'(lane_c);
        end
        found_c = 1'b1;
      end
    end
    take_c         = (chunk_q == '0) || (chunk_max_c > best_score_q);
    merged_score_c = take_c ? chunk_max_c : best_score_q;
    merged_idx_c   = take_c ? chunk_idx_c : best_idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      i_ready      <= 1'b1;
      o_valid      <= 1'b0;
      o_class      <= '0;
      o_max_score  <= '0;
      chunk_q      <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      for (int j = 0; j < int'(NUM_CLASSES); j++) elems_q[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            for (int j = 0; j < int'(NUM_CLASSES); j++)
              elems_q[j] <= i_scores[j*DATA_WIDTH +: DATA_WIDTH];
            chunk_q      <= '0;
            best_score_q <= MIN_SCORE;
            best_idx_q   <= '0;
            i_ready      <= 1'b0;
            state        <= SCAN;
          end
        end
        SCAN: begin
          best_score_q <= merged_score_c;
          best_idx_q   <= merged_idx_c;
          if (chunk_q == LAST_CHUNK) begin
            o_class     <= merged_idx_c;
            o_max_score <= merged_score_c;
            o_valid     <= 1'b1;
            state       <= DONE;
          end else begin
            chunk_q <= chunk_q + CHUNK_W'(1);
          end
        end
        DONE: begin
          if (o_ready) begin
            o_valid <= 1'b0;
            i_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          i_ready <= 1'b1;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// Self-checking bench for argmax_classifier: directed cases plus randomized
// back-to-back vectors against a cycle-level behavioural argmax model.
module tb_argmax_classifier;

  localparam int NC = 10;
  localparam int DW = 8;
  localparam int IW = 4;
  localparam int C  = 3;

  logic             clk;
  logic             rst;
  logic             i_valid;
  logic             i_ready;
  logic [NC*DW-1:0] i_scores;
  logic             o_valid;
  logic             o_ready;
  logic [IW-1:0]    o_class;
  logic [DW-1:0]    o_max_score;

  int n_cmp = 0;
  int n_bad = 0;

  argmax_classifier #(.NUM_CLASSES(NC), .DATA_WIDTH(DW), .SCAN_FACTOR(4)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_scores(i_scores),
    .o_valid(o_valid), .o_ready(o_ready), .o_class(o_class), .o_max_score(o_max_score)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference argmax: first occurrence of the largest signed value.
  function automatic void ref_argmax(input logic [NC*DW-1:0] v, output int cls, output int sc);
    int val;
    cls = 0;
    sc  = int'($signed(v[DW-1:0]));
    for (int j = 1; j < NC; j++) begin
      val = int'($signed(v[j*DW +: DW]));
      if (val > sc) begin
        sc  = val;
        cls = j;
      end
    end
  endfunction

  function automatic logic [NC*DW-1:0] pack(input int v[NC]);
    logic [NC*DW-1:0] r;
    for (int j = 0; j < NC; j++) r[j*DW +: DW] = DW'(v[j]);
    return r;
  endfunction

  function automatic logic [NC*DW-1:0] rand_vec();
    logic [NC*DW-1:0] r;
    int pick;
    for (int j = 0; j < NC; j++) begin
      if ($urandom_range(0, 2) == 0) begin
        pick = int'($urandom_range(0, 3));
        r[j*DW +: DW] = (pick == 0) ? 8'h80 : (pick == 1) ? 8'h7f : (pick == 2) ? 8'h00 : 8'h01;
      end else begin
        r[j*DW +: DW] = DW'($urandom);
      end
    end
    return r;
  endfunction

  // Behavioural model: accept when ready, result C cycles later, held until taken.
  logic m_ready, m_valid;
  int   m_cls, m_score, m_cnt, p_cls, p_score;

  always @(negedge clk) begin
    if (rst) begin
      check("reset_i_ready", int'(i_ready), 1);
      check("reset_o_valid", int'(o_valid), 0);
      check("reset_o_class", int'(o_class), 0);
      check("reset_o_max_score", int'($signed(o_max_score)), 0);
      m_ready = 1'b1; m_valid = 1'b0; m_cls = 0; m_score = 0; m_cnt = 0;
    end else begin
      check("mon_i_ready", int'(i_ready), int'(m_ready));
      check("mon_o_valid", int'(o_valid), int'(m_valid));
      check("mon_o_class", int'(o_class), m_cls);
      check("mon_o_max_score", int'($signed(o_max_score)), m_score);
      if (m_ready && i_valid) begin
        ref_argmax(i_scores, p_cls, p_score);
        m_ready = 1'b0;
        m_cnt   = C;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_valid = 1'b1; m_cls = p_cls; m_score = p_score;
        end
      end else if (m_valid && o_ready) begin
        m_valid = 1'b0;
        m_ready = 1'b1;
      end
    end
  end

  // Present a vector for one accepted cycle; returns after the accept edge (+1).
  task automatic send_vec(input logic [NC*DW-1:0] v);
    int guard = 0;
    while (!i_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 50) check("send_timeout", 0, 1);
    i_scores = v;
    i_valid  = 1'b1;
    @(posedge clk); #1;
    i_valid  = 1'b0;
  endtask

  // Waits for o_valid; lat = edges after the accept edge until it rose.
  task automatic wait_result(output int lat);
    int cnt = 0;
    lat = -1;
    while (cnt < 50) begin
      @(negedge clk);
      cnt++;
      if (o_valid) begin
        lat = cnt - 1;
        break;
      end
    end
    if (lat < 0) check("result_timeout", 0, 1);
  endtask

  task automatic run_vec(input int v[NC], input int exp_cls, input int exp_sc, input string name);
    int lat;
    send_vec(pack(v));
    wait_result(lat);
    check({name, "_class"}, int'(o_class), exp_cls);
    check({name, "_score"}, int'($signed(o_max_score)), exp_sc);
    @(posedge clk); #1;
  endtask

  initial begin
    int tv[NC];
    int lat, cls, sc, acc, guard, saved_cls, saved_sc;
    logic took;
    logic [NC*DW-1:0] vb;

    rst = 1'b0; i_valid = 1'b0; o_ready = 1'b1; i_scores = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Pin the reference model itself.
    tv = '{3, -5, 7, 1, 0, 2, -1, 9, 4, 6};
    ref_argmax(pack(tv), cls, sc);
    check("model_basic_class", cls, 7);
    check("model_basic_score", sc, 9);
    tv = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
    ref_argmax(pack(tv), cls, sc);
    check("model_min_class", cls, 0);
    check("model_min_score", sc, -128);

    // Basic vector with latency and handshake timing.
    tv = '{3, -5, 7, 1, 0, 2, -1, 9, 4, 6};
    send_vec(pack(tv));
    check("basic_ready_drop", int'(i_ready), 0);
    wait_result(lat);
    check("basic_latency", lat, C);
    check("basic_class", int'(o_class), 7);
    check("basic_score", int'($signed(o_max_score)), 9);
    @(posedge clk); #1;
    check("basic_ready_back", int'(i_ready), 1);
    check("basic_valid_drop", int'(o_valid), 0);

    tv = '{10, 10, 50, 10, 10, 10, 10, 10, 10, 50};
    run_vec(tv, 2, 50, "tie_across");
    tv = '{10, 10, 10, 10, 50, 50, 10, 10, 10, 10};
    run_vec(tv, 4, 50, "tie_within");
    tv = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -128};
    run_vec(tv, 0, -128, "all_min");
    tv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 127};
    run_vec(tv, 9, 127, "pad_chunk");
    tv = '{-1, -1, -1, -1, -1, -1, -1, -1, -1, -1};
    run_vec(tv, 0, -1, "pad_negative");

    // Backpressure in DONE with a competing vector on the input.
    o_ready = 1'b0;
    tv = '{1, 2, 3, 4, 5, 6, 7, 8, 9, -9};
    send_vec(pack(tv));
    wait_result(lat);
    saved_cls = int'(o_class);
    saved_sc  = int'($signed(o_max_score));
    check("bp_class", saved_cls, 8);
    check("bp_score", saved_sc, 9);
    @(posedge clk); #1;
    tv = '{0, 0, 0, 0, 0, 0, 100, 0, 0, 0};
    vb = pack(tv);
    i_scores = vb;
    i_valid  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_valid", int'(o_valid), 1);
      check("bp_hold_ready", int'(i_ready), 0);
      check("bp_hold_class", int'(o_class), saved_cls);
      check("bp_hold_score", int'($signed(o_max_score)), saved_sc);
    end
    @(posedge clk); #1;
    o_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", int'(o_valid), 0);
    check("bp_release_ready", int'(i_ready), 1);
    @(posedge clk); #1;
    check("bp_next_accept", int'(i_ready), 0);
    i_valid = 1'b0;
    wait_result(lat);
    check("bp_next_class", int'(o_class), 6);
    check("bp_next_score", int'($signed(o_max_score)), 100);
    @(posedge clk); #1;

    // Reset while chunk 1 is being scanned.
    tv = '{5, 5, 5, 5, 99, 5, 5, 5, 5, 5};
    send_vec(pack(tv));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_scan_valid", int'(o_valid), 0);
    check("rst_scan_ready", int'(i_ready), 1);
    check("rst_scan_class", int'(o_class), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, -3};
    run_vec(tv, 0, 0, "post_rst");

    // Randomized back-to-back traffic with i_valid held high.
    i_valid  = 1'b1;
    i_scores = rand_vec();
    acc = 0;
    guard = 0;
    while (acc < 200 && guard < 20000) begin
      @(negedge clk);
      took = i_ready;
      @(posedge clk); #1;
      guard++;
      if (took) begin
        acc++;
        i_scores = rand_vec();
      end
      o_ready = ($urandom_range(0, 3) != 0);
    end
    if (guard >= 20000) check("random_timeout", 0, 1);
    i_valid = 1'b0;
    o_ready = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(i_ready && !o_valid) && guard < 50);
    check("drain_idle", int'(i_ready && !o_valid), 1);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
